// File: rtl/rvh_l1d_mshr_file.sv
// L1D bank miss-status holding register file.
// Allocates free entries, dedups lines via CAM and issues L2 reads in order.
module rvh_l1d_mshr_file #(
    parameter int N_MSHR       = 4,
    parameter int PADDR_WIDTH  = 20,
    parameter int OFFSET_WIDTH = 6,
    parameter int TXN_W        = 4,
    localparam int IDX_W       = $clog2(N_MSHR),
    localparam int LINE_W      = PADDR_WIDTH - OFFSET_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  logic [PADDR_WIDTH-1:0] alloc_paddr_i,
    input  logic [TXN_W-1:0]       alloc_txn_i,
    input  logic                   alloc_no_l2_i,
    output logic [IDX_W-1:0]       alloc_idx_o,
    input  logic [PADDR_WIDTH-1:0] lookup_paddr_i,
    output logic                   lookup_hit_o,
    output logic [IDX_W-1:0]       lookup_idx_o,
    output logic                   l2_ar_valid_o,
    input  logic                   l2_ar_ready_i,
    output logic [IDX_W-1:0]       l2_ar_id_o,
    output logic [PADDR_WIDTH-1:0] l2_ar_addr_o,
    output logic [TXN_W-1:0]       l2_ar_txn_o,
    input  logic                   dealloc_valid_i,
    input  logic [IDX_W-1:0]       dealloc_idx_i,
    input  logic                   flush_i,
    output logic [N_MSHR-1:0]      entry_valid_o,
    output logic [N_MSHR-1:0]      entry_issued_o,
    output logic [N_MSHR-1:0]      entry_no_resp_o,
    output logic                   full_o
);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_QUEUED,
        ST_ISSUED,
        ST_LOCAL
    } state_e;

    state_e            state   [N_MSHR];
    logic [LINE_W-1:0] line_q  [N_MSHR];
    logic [TXN_W-1:0]  txn_q   [N_MSHR];
    logic [N_MSHR-1:0] no_resp_q;
    logic [N_MSHR-1:0] no_resp_nxt;

    logic [IDX_W-1:0]  ar_q    [N_MSHR];
    logic [IDX_W-1:0]  wr_ptr;
    logic [IDX_W-1:0]  rd_ptr;
    logic [IDX_W:0]    count;

    logic              alloc_hit;
    logic              free_found;
    logic              alloc_fire;
    logic              push;
    logic              pop;
    logic              dealloc_ok;
    logic [IDX_W-1:0]  head;
    logic              unused_offset;

    assign unused_offset = ^{alloc_paddr_i[OFFSET_WIDTH-1:0],
                             lookup_paddr_i[OFFSET_WIDTH-1:0]};

    always_comb begin
        entry_valid_o  = '0;
        entry_issued_o = '0;
        lookup_hit_o   = 1'b0;
        lookup_idx_o   = '0;
        alloc_hit      = 1'b0;
        free_found     = 1'b0;
        alloc_idx_o    = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            entry_valid_o[i]  = (state[i] != ST_FREE);
            entry_issued_o[i] = (state[i] == ST_ISSUED) || (state[i] == ST_LOCAL);
            if (entry_valid_o[i] &&
                line_q[i] == lookup_paddr_i[PADDR_WIDTH-1:OFFSET_WIDTH]) begin
                lookup_hit_o = 1'b1;
                lookup_idx_o = IDX_W'(i);
            end
            if (entry_valid_o[i] &&
                line_q[i] == alloc_paddr_i[PADDR_WIDTH-1:OFFSET_WIDTH]) begin
                alloc_hit = 1'b1;
            end
            if (!free_found && !entry_valid_o[i]) begin
                free_found  = 1'b1;
                alloc_idx_o = IDX_W'(i);
            end
        end
    end

    assign full_o        = !free_found;
    assign alloc_ready_o = free_found && !alloc_hit;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;
    assign push          = alloc_fire && !alloc_no_l2_i;

    assign head          = ar_q[rd_ptr];
    assign l2_ar_valid_o = (count != '0);
    assign pop           = l2_ar_valid_o && l2_ar_ready_i;
    assign l2_ar_id_o    = head;
    assign l2_ar_addr_o  = {line_q[head], {OFFSET_WIDTH{1'b0}}};
    assign l2_ar_txn_o   = txn_q[head];

    assign dealloc_ok = dealloc_valid_i &&
                        (state[dealloc_idx_i] == ST_ISSUED ||
                         state[dealloc_idx_i] == ST_LOCAL);

    // Flush marks survivors and the newcomer; a freed entry always leaves clean.
    always_comb begin
        no_resp_nxt = no_resp_q;
        for (int i = 0; i < N_MSHR; i++) begin
            if (alloc_fire && alloc_idx_o == IDX_W'(i))
                no_resp_nxt[i] = 1'b0;
            if (flush_i && (entry_valid_o[i] ||
                            (alloc_fire && alloc_idx_o == IDX_W'(i))))
                no_resp_nxt[i] = 1'b1;
            if (dealloc_ok && dealloc_idx_i == IDX_W'(i))
                no_resp_nxt[i] = 1'b0;
        end
    end

    assign entry_no_resp_o = no_resp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_MSHR; i++) begin
                state[i]  <= ST_FREE;
                line_q[i] <= '0;
                txn_q[i]  <= '0;
                ar_q[i]   <= '0;
            end
            no_resp_q <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                if (alloc_fire && alloc_idx_o == IDX_W'(i)) begin
                    state[i]  <= alloc_no_l2_i ? ST_LOCAL : ST_QUEUED;
                    line_q[i] <= alloc_paddr_i[PADDR_WIDTH-1:OFFSET_WIDTH];
                    txn_q[i]  <= alloc_txn_i;
                end else if (pop && head == IDX_W'(i)) begin
                    state[i] <= ST_ISSUED;
                end else if (dealloc_ok && dealloc_idx_i == IDX_W'(i)) begin
                    state[i] <= ST_FREE;
                end
            end
            no_resp_q <= no_resp_nxt;
            if (push) begin
                ar_q[wr_ptr] <= alloc_idx_o;
                wr_ptr       <= wr_ptr + IDX_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + IDX_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (IDX_W+1)'(1);
                2'b01:   count <= count - (IDX_W+1)'(1);
                default: count <= count;
            endcase
            if (dealloc_valid_i)
                assert (dealloc_ok)
                else $warning("mshr dealloc of non-issued entry %0d ignored",
                              dealloc_idx_i);
        end
    end

endmodule
